// File: rtl/pwm_ramp_pkg.sv
// Shared definitions for the PWM-ramp converter family (ADC ramp and DAC).
// Provides the default code width, the full-scale code helper and the duty
// code type. Full scale MAX = 2^n-1 is also the PWM period in ticks, which
// makes an ADC->DAC loopback unity-gain.
package pwm_ramp_pkg;

  localparam int NBITS_DEF = 6;

  typedef logic [NBITS_DEF-1:0] duty_t;

  function automatic int unsigned max_code(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Tick prescaler shared by the PWM ramp blocks.
// Ports:
//   clk_i       system clock
//   rst_ni      synchronous active-low reset
//   enable_i    run the prescaler; low holds the count at 0 and masks tick
//   prescale_i  one tick every prescale_i+1 clocks
//   tick_o      combinational tick strobe for the current clock
module pwm_prescaler #(
  parameter int PSBITS = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [PSBITS-1:0] prescale_i,
  output logic              tick_o
);

  logic [PSBITS-1:0] presc_q;

  // >= rather than == so that lowering prescale_i mid-count ticks on the
  // next clock instead of running the counter round past 2^PSBITS.
  assign tick_o = enable_i && (presc_q >= prescale_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      presc_q <= '0;
    end else if (!enable_i || tick_o) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC: turns a stream of NBITS duty codes into a PWM wave whose mean,
// after the external RC filter, is code/(2^NBITS-1) of VDD.
// Ports:
//   clk_i           system clock
//   rst_ni          synchronous active-low reset
//   enable_i        run PWM; low idles with pwm_o low and preloads duty
//   prescale_i      one tick every prescale_i+1 clocks
//   sample_i        duty code 0..MAX
//   sample_valid_i  sample_i valid
//   sample_ready_o  shadow register empty (no path from sample_valid_i)
//   pwm_o           registered PWM output
//   period_start_o  1-clk pulse on the first clock of a new period
//   underrun_o      1-clk pulse when a period began with no new sample
module pwm_dac
  import pwm_ramp_pkg::*;
#(
  parameter int NBITS  = NBITS_DEF,
  parameter int PSBITS = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [PSBITS-1:0] prescale_i,
  input  logic [NBITS-1:0]  sample_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  output logic              pwm_o,
  output logic              period_start_o,
  output logic              underrun_o
);

  localparam logic [NBITS-1:0] LAST_CNT = NBITS'(max_code(NBITS) - 1);

  logic             tick;
  logic             wrap;
  logic             accept;
  logic             load;
  logic [NBITS-1:0] cnt_q;
  logic [NBITS-1:0] duty_q;
  logic [NBITS-1:0] shadow_q;
  logic             shadow_full_q;

  pwm_prescaler #(
    .PSBITS(PSBITS)
  ) u_presc (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .enable_i   (enable_i),
    .prescale_i (prescale_i),
    .tick_o     (tick)
  );

  assign wrap           = tick && (cnt_q == LAST_CNT);
  assign sample_ready_o = !shadow_full_q;
  assign accept         = sample_valid_i && !shadow_full_q;
  // Duty only changes at a period boundary, or freely while idle (preload).
  // load and accept are exclusive: accept needs an empty shadow.
  assign load           = shadow_full_q && (!enable_i || wrap);

  // Period counter: 0..MAX-1, so one period is MAX ticks.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!enable_i || wrap) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Shadow/duty registers. A sample accepted on the wrap clock itself lands
  // in the shadow and is applied one period later.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      duty_q        <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
    end else if (load) begin
      duty_q        <= shadow_q;
      shadow_full_q <= 1'b0;
    end else if (accept) begin
      shadow_q      <= sample_i;
      shadow_full_q <= 1'b1;
    end
  end

  // Output flops: pwm_o lags cnt_q by one clock; pulses mark the first
  // clock of the new period. tick (hence wrap) is already gated by enable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pwm_o          <= 1'b0;
      period_start_o <= 1'b0;
      underrun_o     <= 1'b0;
    end else begin
      pwm_o          <= enable_i && (duty_q > cnt_q);
      period_start_o <= wrap;
      underrun_o     <= wrap && !shadow_full_q;
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Directed testbench for pwm_dac (NBITS=6, PSBITS=8).
module tb_pwm_dac;

  logic       clk;
  logic       rst_ni;
  logic       enable_i;
  logic [7:0] prescale_i;
  logic [5:0] sample_i;
  logic       sample_valid_i;
  logic       sample_ready_o;
  logic       pwm_o;
  logic       period_start_o;
  logic       underrun_o;

  int tests_run;
  int tests_failed;

  logic [5:0] q[$];

  pwm_dac #(
    .NBITS  (6),
    .PSBITS (8)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .enable_i       (enable_i),
    .prescale_i     (prescale_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .pwm_o          (pwm_o),
    .period_start_o (period_start_o),
    .underrun_o     (underrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs n clocks starting from a negedge, feeding queued codes through the
  // handshake and counting pwm_o high clocks, pulses and accepted samples.
  task automatic run(input int n, output int hi, output int ps, output int ur, output int acc);
    bit fire;
    hi = 0; ps = 0; ur = 0; acc = 0;
    for (int i = 0; i < n; i++) begin
      if (q.size() > 0) begin
        sample_valid_i = 1'b1;
        sample_i       = q[0];
      end else begin
        sample_valid_i = 1'b0;
      end
      fire = sample_valid_i && sample_ready_o;
      @(negedge clk);
      if (pwm_o)          hi++;
      if (period_start_o) ps++;
      if (underrun_o)     ur++;
      if (fire) begin
        void'(q.pop_front());
        acc++;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (pwm_o !== 1'b0) begin tests_failed++; $display("FAIL reset_pwm: got %b expected 0", pwm_o); end
    tests_run++; if (period_start_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ps: got %b expected 0", period_start_o); end
    tests_run++; if (underrun_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ur: got %b expected 0", underrun_o); end
    tests_run++; if (sample_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", sample_ready_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_preload();
    int hi, ps, ur, acc;
    q.push_back(6'd32);
    run(2, hi, ps, ur, acc);
    tests_run++; if (acc !== 1) begin tests_failed++; $display("FAIL preload_accept: got %0d expected 1", acc); end
    tests_run++; if (hi !== 0) begin tests_failed++; $display("FAIL preload_idle_pwm: got %0d expected 0", hi); end
    tests_run++; if (sample_ready_o !== 1'b1) begin tests_failed++; $display("FAIL preload_ready: got %b expected 1", sample_ready_o); end
    enable_i = 1'b1;
    for (int p = 0; p < 2; p++) begin
      run(63, hi, ps, ur, acc);
      tests_run++; if (hi !== 32) begin tests_failed++; $display("FAIL preload_high[%0d]: got %0d expected 32", p, hi); end
      tests_run++; if (ps !== 1) begin tests_failed++; $display("FAIL preload_ps[%0d]: got %0d expected 1", p, ps); end
      tests_run++; if (ur !== 1) begin tests_failed++; $display("FAIL preload_ur[%0d]: got %0d expected 1", p, ur); end
    end
  endtask

  task automatic test_extremes();
    int hi, ps, ur, acc;
    q.push_back(6'd0);
    run(63, hi, ps, ur, acc);
    tests_run++; if (hi !== 32) begin tests_failed++; $display("FAIL ext_old_high: got %0d expected 32", hi); end
    tests_run++; if (ur !== 0) begin tests_failed++; $display("FAIL ext_old_ur: got %0d expected 0", ur); end
    q.push_back(6'd63);
    run(63, hi, ps, ur, acc);
    tests_run++; if (hi !== 0) begin tests_failed++; $display("FAIL ext_zero_high: got %0d expected 0", hi); end
    tests_run++; if (ps !== 1) begin tests_failed++; $display("FAIL ext_zero_ps: got %0d expected 1", ps); end
    run(63, hi, ps, ur, acc);
    tests_run++; if (hi !== 63) begin tests_failed++; $display("FAIL ext_full_high: got %0d expected 63", hi); end
    tests_run++; if (ur !== 1) begin tests_failed++; $display("FAIL ext_full_ur: got %0d expected 1", ur); end
  endtask

  task automatic test_back_to_back();
    int hi, ps, ur, acc;
    int exp_hi[4]  = '{63, 10, 20, 30};
    int exp_acc[4] = '{1, 1, 1, 0};
    int exp_ur[4]  = '{0, 0, 0, 1};
    q.push_back(6'd10);
    q.push_back(6'd20);
    q.push_back(6'd30);
    for (int p = 0; p < 4; p++) begin
      run(63, hi, ps, ur, acc);
      tests_run++; if (hi !== exp_hi[p]) begin tests_failed++; $display("FAIL b2b_high[%0d]: got %0d expected %0d", p, hi, exp_hi[p]); end
      tests_run++; if (acc !== exp_acc[p]) begin tests_failed++; $display("FAIL b2b_accepts[%0d]: got %0d expected %0d", p, acc, exp_acc[p]); end
      tests_run++; if (ur !== exp_ur[p]) begin tests_failed++; $display("FAIL b2b_ur[%0d]: got %0d expected %0d", p, ur, exp_ur[p]); end
    end
  endtask

  task automatic test_underrun();
    int hi, ps, ur, acc;
    for (int p = 0; p < 2; p++) begin
      run(63, hi, ps, ur, acc);
      tests_run++; if (hi !== 30) begin tests_failed++; $display("FAIL ur_hold_high[%0d]: got %0d expected 30", p, hi); end
      tests_run++; if (ur !== 1) begin tests_failed++; $display("FAIL ur_pulse[%0d]: got %0d expected 1", p, ur); end
      tests_run++; if (ps !== 1) begin tests_failed++; $display("FAIL ur_ps[%0d]: got %0d expected 1", p, ps); end
    end
  endtask

  task automatic test_prescale();
    int hi, ps, ur, acc;
    int seen;
    enable_i = 1'b0;
    q.push_back(6'd16);
    run(2, hi, ps, ur, acc);
    tests_run++; if (ps + ur !== 0) begin tests_failed++; $display("FAIL ps_idle_pulses: got %0d expected 0", ps + ur); end
    prescale_i = 8'd3;
    enable_i   = 1'b1;
    run(252, hi, ps, ur, acc);
    tests_run++; if (hi !== 64) begin tests_failed++; $display("FAIL ps3_high: got %0d expected 64", hi); end
    tests_run++; if (ps !== 1) begin tests_failed++; $display("FAIL ps3_period: got %0d expected 1", ps); end
    // Two more clocks leave the prescaler at 2; lowering the setting to 0
    // must tick on the very next clock, so the next wrap comes 62 clocks on.
    run(2, hi, ps, ur, acc);
    prescale_i = 8'd0;
    seen = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (period_start_o) begin
        seen = i;
        break;
      end
    end
    tests_run++; if (seen !== 62) begin tests_failed++; $display("FAIL ps_drop_wrap: got %0d expected 62", seen); end
  endtask

  task automatic test_reset_mid();
    int hi, ps, ur, acc;
    q.push_back(6'd40);
    run(5, hi, ps, ur, acc);
    tests_run++; if (sample_ready_o !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_full: got %b expected 0", sample_ready_o); end
    rst_ni = 1'b0;
    @(negedge clk);
    tests_run++; if (pwm_o !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_pwm: got %b expected 0", pwm_o); end
    tests_run++; if (sample_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ready: got %b expected 1", sample_ready_o); end
    tests_run++; if (period_start_o !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_ps: got %b expected 0", period_start_o); end
    rst_ni = 1'b1;
    run(126, hi, ps, ur, acc);
    tests_run++; if (hi !== 0) begin tests_failed++; $display("FAIL rst_mid_discard: got %0d expected 0", hi); end
    tests_run++; if (ps !== 2) begin tests_failed++; $display("FAIL rst_mid_periods: got %0d expected 2", ps); end
    tests_run++; if (ur !== 2) begin tests_failed++; $display("FAIL rst_mid_ur: got %0d expected 2", ur); end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst_ni         = 1'b0;
    enable_i       = 1'b0;
    prescale_i     = 8'd0;
    sample_i       = 6'd0;
    sample_valid_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_preload();
    test_extremes();
    test_back_to_back();
    test_underrun();
    test_prescale();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
